seq_shifter: RTL and testbench

- Multi-cycle iterative shift unit for the multi-cycle MIPS datapath.
- It computes the same functions as the single-cycle combinational shifter: SLL, SRL and SRA of a 32-bit operand by B[4:0].
- It shifts by at most STEP bits per cycle and uses valid/ready handshakes on both sides.
- It sits between the ID/EX operand latch and the writeback mux, and stalls the core while busy.

---
 rtl/shift_defs.sv | 24 ++
 rtl/shift_step.sv | 30 +++
 rtl/seq_shifter.sv | 91 +++++++++
 tb/tb_seq_shifter.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/shift_defs.sv
// Shared shifter constants: Shiftop encodings, datapath width and sequencer states.
// No logic and no latency; used by both the iterative and the combinational shifter.
package shift_defs;

  localparam int DATA_WIDTH = 32;
  localparam int SHAMT_W    = 5;

  localparam logic [1:0] SHIFT_L   = 2'b00;
  localparam logic [1:0] SHIFT_RSV = 2'b01;
  localparam logic [1:0] SHIFT_LR  = 2'b10;
  localparam logic [1:0] SHIFT_AR  = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic logic [SHAMT_W-1:0] min_shamt(input logic [SHAMT_W-1:0] a,
                                                   input logic [SHAMT_W-1:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/shift_step.sv
// One shift increment of at most STEP bits.
// Purely combinational (zero latency); it has no handshake, so it exerts no backpressure.
module shift_step
  import shift_defs::*;
#(
  parameter int DATA_WIDTH = shift_defs::DATA_WIDTH,
  parameter int STEP       = 4,
  localparam int KW        = $clog2(STEP + 1)
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic [KW-1:0]         k,
  input  logic [1:0]            op,
  input  logic                  fill,
  output logic [DATA_WIDTH-1:0] shifted
);

  logic [2*DATA_WIDTH-1:0] ext;

  // Right shifts pull fill bits in from an upper half that replicates the fill value.
  always_comb begin
    ext     = {{DATA_WIDTH{fill & (op == SHIFT_AR)}}, data};
    shifted = '0;
    case (op)
      SHIFT_L:            shifted = data << k;
      SHIFT_LR, SHIFT_AR: shifted = DATA_WIDTH'(ext >> k);
      default:            shifted = '0;
    endcase
  end

endmodule

// File: rtl/seq_shifter.sv
// Iterative SLL/SRL/SRA unit: latency 1 + ceil(shamt/STEP) cycles (1 for shamt 0 or op 01).
// One op in flight: in_ready only in IDLE; DONE holds Result until out_ready.
module seq_shifter
  import shift_defs::*;
#(
  parameter int DATA_WIDTH = shift_defs::DATA_WIDTH,
  parameter int STEP       = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  input  logic [1:0]            Shiftop,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] Result
);

  localparam int KW = $clog2(STEP + 1);
  localparam logic [SHAMT_W-1:0] STEP_AMT = SHAMT_W'(STEP);

  state_t               state, state_nxt;
  logic [DATA_WIDTH-1:0] data_q, data_step;
  logic [SHAMT_W-1:0]    rem_q, k_amt;
  logic [1:0]            op_q;
  logic                  sign_q;
  logic                  accept, last_step;
  logic                  unused_b;

  assign unused_b  = ^B[DATA_WIDTH-1:SHAMT_W];
  assign accept    = in_valid && (state == IDLE);
  assign k_amt     = min_shamt(rem_q, STEP_AMT);
  // rem - k reaches zero exactly when the remainder fits in one step.
  assign last_step = (rem_q == k_amt);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (Shiftop == SHIFT_RSV || B[SHAMT_W-1:0] == '0) state_nxt = DONE;
          else                                               state_nxt = SHIFT;
        end
      end
      SHIFT:   if (last_step) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  shift_step #(
    .DATA_WIDTH(DATA_WIDTH),
    .STEP      (STEP)
  ) u_step (
    .data   (data_q),
    .k      (k_amt[KW-1:0]),
    .op     (op_q),
    .fill   (sign_q),
    .shifted(data_step)
  );

  // The sign bit is kept apart from data_q so SRA fill does not depend on partially shifted data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q <= '0;
      rem_q  <= '0;
      op_q   <= SHIFT_L;
      sign_q <= 1'b0;
    end else if (accept) begin
      data_q <= (Shiftop == SHIFT_RSV) ? '0 : A;
      rem_q  <= B[SHAMT_W-1:0];
      op_q   <= Shiftop;
      sign_q <= A[DATA_WIDTH-1];
    end else if (state == SHIFT) begin
      data_q <= data_step;
      rem_q  <= rem_q - k_amt;
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign Result    = data_q;

endmodule

// File: tb/tb_seq_shifter.sv
// Bench for seq_shifter: directed cases on STEP=4, then random regression on STEP 1/4/16,
// all checked against an arithmetic reference of the shift and its latency.
module tb_seq_shifter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] a_in, b_in;
  logic [1:0]  op_in;
  logic        iv[3], ir[3], ov[3], ordy[3];
  logic [31:0] res[3];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  generate
    for (genvar g = 0; g < 3; g++) begin : g_dut
      seq_shifter #(
        .DATA_WIDTH(32),
        .STEP      ((g == 0) ? 1 : ((g == 1) ? 4 : 16))
      ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (iv[g]),
        .in_ready (ir[g]),
        .A        (a_in),
        .B        (b_in),
        .Shiftop  (op_in),
        .out_valid(ov[g]),
        .out_ready(ordy[g]),
        .Result   (res[g])
      );
    end
  endgenerate

  function automatic int step_of(input int d);
    return (d == 0) ? 1 : ((d == 1) ? 4 : 16);
  endfunction

  function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic [1:0] op);
    int sh;
    sh = int'(b[4:0]);
    case (op)
      2'b00:   return a << sh;
      2'b10:   return a >> sh;
      2'b11:   return 32'($signed(a) >>> sh);
      default: return 32'h0;
    endcase
  endfunction

  function automatic int model_lat(input logic [31:0] b, input logic [1:0] op, input int step);
    int sh;
    sh = int'(b[4:0]);
    if (op == 2'b01 || sh == 0) return 1;
    return 1 + (sh + step - 1) / step;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Entered away from a clock edge with the selected DUT idle; leaves #1 after the handshake edge.
  task automatic run_op(input int d, input logic [31:0] a, input logic [31:0] b,
                        input logic [1:0] op, input int hold, input string tag,
                        output logic [31:0] got);
    int          lat;
    bit          ready_bad, stable_bad, timeout;
    logic [31:0] first;
    check({tag, " idle_ready"}, 32'(ir[d]), 32'h1);
    a_in  = a;
    b_in  = b;
    op_in = op;
    iv[d] = 1'b1;
    @(posedge clk);
    #1;
    iv[d] = 1'b0;
    a_in  = $urandom;
    b_in  = $urandom;
    op_in = 2'($urandom_range(0, 3));
    lat = 1; ready_bad = 0; timeout = 0;
    while (!ov[d] && !timeout) begin
      if (ir[d]) ready_bad = 1;
      @(posedge clk);
      #1;
      lat++;
      if (lat > 40) timeout = 1;
    end
    if (ir[d]) ready_bad = 1;
    check({tag, " latency"}, 32'(lat), 32'(model_lat(b, op, step_of(d))));
    check({tag, " busy_ready"}, 32'(ready_bad), 32'h0);
    check({tag, " result"}, res[d], model(a, b, op));
    got        = res[d];
    first      = res[d];
    stable_bad = 0;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      if (!ov[d] || ir[d] || res[d] !== first) stable_bad = 1;
    end
    if (hold > 0) check({tag, " hold_stable"}, 32'(stable_bad), 32'h0);
    ordy[d] = 1'b1;
    @(posedge clk);
    #1;
    ordy[d] = 1'b0;
    check({tag, " after_handshake"}, 32'({ov[d], ir[d]}), 32'h1);
  endtask

  initial begin
    logic [31:0] got, a, b;
    logic [1:0]  op;
    int          hold;

    for (int d = 0; d < 3; d++) begin
      iv[d]   = 1'b0;
      ordy[d] = 1'b0;
    end
    a_in  = 32'h0;
    b_in  = 32'h0;
    op_in = 2'b00;

    #12;
    for (int d = 0; d < 3; d++) begin
      check($sformatf("reset_in_ready%0d", d), 32'(ir[d]), 32'h1);
      check($sformatf("reset_out_valid%0d", d), 32'(ov[d]), 32'h0);
      check($sformatf("reset_result%0d", d), res[d], 32'h0);
    end
    #5 rst = 1'b1;
    @(posedge clk);
    #1;

    run_op(1, 32'h0000_0001, 32'd31, 2'b00, 0, "sll31", got);
    check("sll31 const", got, 32'h8000_0000);
    run_op(1, 32'h8000_0000, 32'd4, 2'b11, 0, "sra4", got);
    check("sra4 const", got, 32'hF800_0000);
    run_op(1, 32'h8000_0000, 32'd4, 2'b10, 0, "srl4", got);
    check("srl4 const", got, 32'h0800_0000);
    run_op(1, 32'hDEAD_BEEF, 32'hFFFF_FFE0, 2'b10, 0, "shamt0", got);
    check("shamt0 const", got, 32'hDEAD_BEEF);
    run_op(1, 32'hCAFE_F00D, 32'd7, 2'b01, 0, "rsvd", got);
    check("rsvd const", got, 32'h0);
    run_op(1, 32'h1234_5678, 32'd8, 2'b00, 5, "bp", got);
    check("bp const", got, 32'h3456_7800);

    // Abort a SHIFT in progress with an asynchronous mid-cycle reset.
    a_in  = 32'hFFFF_0000;
    b_in  = 32'd20;
    op_in = 2'b00;
    iv[1] = 1'b1;
    @(posedge clk);
    #1;
    iv[1] = 1'b0;
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("abort out_valid", 32'(ov[1]), 32'h0);
    check("abort in_ready", 32'(ir[1]), 32'h1);
    check("abort result", res[1], 32'h0);
    #10 rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort post_release out_valid", 32'(ov[1]), 32'h0);
    run_op(1, 32'h0000_000F, 32'd1, 2'b00, 0, "post_abort", got);
    check("post_abort const", got, 32'h0000_001E);

    for (int d = 0; d < 3; d++) begin
      for (int n = 0; n < 1500; n++) begin
        a  = $urandom;
        b  = $urandom;
        if ($urandom_range(0, 7) == 0) b[4:0] = 5'd0;
        op = 2'($urandom_range(0, 3));
        hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
        run_op(d, a, b, op, hold, $sformatf("rnd_s%0d_%0d", step_of(d), n), got);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
